// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encoding,
// opcodes, ALUOp / ALU control / immediate / mux select codes.
package mc_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source muxes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Immediate format selected purely from the opcode; unknown opcodes use I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle control FSM (master) and the
// shared datapath (slave).
interface multicycle_control_fsm_if #(parameter int STATE_W = 4);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_src;
  logic [2:0]         alu_control;
  logic               reg_write;
  logic               illegal_instr;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, illegal_instr, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, illegal_instr, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct fields to alu_control.
// Subtract only for R-type (op5=1) with funct7b5 set; I-type add never subtracts.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Decode ALUOp, then funct3 when the FSM defers to the instruction
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit (lw, sw, R-type, I-type ALU, beq, jal).
// One Moore FSM sequences a shared PC/IR/regfile/ALU/unified-memory datapath.
// Optional build macro MCFSM_BNE_EN: also accept bne (branch taken = zero ^ funct3[0]).
module multicycle_control_fsm
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);

  state_t     state, next_state;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;
  logic       branch_taken;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state and Moore control outputs (memory handshake gates FETCH/MEMREAD/MEMWRITE)
  always_comb begin
    next_state = state;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC+imm lands in ALUOut for a possible BEQ
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
`ifdef MCFSM_BNE_EN
          OP_BRANCH: begin
            if (bus.funct3[2:1] == 2'b00) begin
              next_state = S_BEQ;
            end else begin
              next_state = S_FETCH;
              illegal    = 1'b1;
            end
          end
`else
          OP_BRANCH:         next_state = S_BEQ;
`endif
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        // PC <= branch target from DECODE; ALUOut <= OldPC+4 for the link write
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

`ifdef MCFSM_BNE_EN
  assign branch_taken = bus.zero ^ bus.funct3[0];
`else
  assign branch_taken = bus.zero;
`endif

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.alu_control)
  );

  // Architectural write strobes are suppressed for the whole reset cycle
  assign bus.pc_write      = ~reset & ((branch & branch_taken) | pc_update);
  assign bus.ir_write      = ~reset & ir_write;
  assign bus.mem_write     = ~reset & mem_write;
  assign bus.reg_write     = ~reset & reg_write;
  assign bus.illegal_instr = ~reset & illegal;
  assign bus.adr_src       = adr_src;
  assign bus.result_src    = result_src;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.imm_src       = imm_src_of(bus.op);
  assign bus.state_dbg     = STATE_W'(state);

endmodule
